// File: rtl/tick_scheduler_pkg.sv
// rtl/tick_scheduler_pkg.sv - shared types, defaults and rotate-priority pick for tick_scheduler
package tick_scheduler_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DIV_W  = 8;
    localparam int MAX_CH     = 16;
    localparam int MAX_CH_W   = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_e;

    // First set bit of req strictly after ptr, wrapping within n channels; one-hot result.
    function automatic logic [MAX_CH-1:0] rr_next(
        input logic [MAX_CH-1:0]   req,
        input logic [MAX_CH_W-1:0] ptr,
        input int                  n
    );
        logic [MAX_CH-1:0] gnt;
        logic              found;
        int                idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = (int'(ptr) + k) % n;
            if ((k <= n) && !found && req[idx[MAX_CH_W-1:0]]) begin
                gnt[idx[MAX_CH_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// rtl/tick_scheduler_rr_arbiter.sv - combinational round-robin pick; pointer register lives in the parent
module tick_scheduler_rr_arbiter
    import tick_scheduler_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    logic [MAX_CH-1:0]   req_ext;
    logic [MAX_CH_W-1:0] ptr_ext;
    logic [MAX_CH-1:0]   gnt_ext;
    logic                unused_gnt_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_CH-1:0]  = req;
        ptr_ext              = '0;
        ptr_ext[CH_W-1:0]    = ptr;
        gnt_ext              = rr_next(req_ext, ptr_ext, NUM_CH);
        gnt                  = gnt_ext[NUM_CH-1:0];
        gnt_any              = |req;
        gnt_idx              = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_ext[i]) begin
                gnt_idx = i[CH_W-1:0];
            end
        end
    end

    assign unused_gnt_ext = |gnt_ext;

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - per-channel tick dividers with round-robin grant; overrun via TICK_SCHEDULER_OVERRUN_EN
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int DIV_W  = DEF_DIV_W,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_in,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              grant_valid,
    output logic [NUM_CH-1:0] grant,
    input  logic              grant_ready,
    output logic [NUM_CH-1:0] overrun,
    input  logic              overrun_clr
);

    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  div_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] accepted;
    logic              accept;

    arb_state_e        state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [CH_W-1:0]   grant_idx_q, grant_idx_d;
    logic              grant_valid_q, grant_valid_d;
    logic [CH_W-1:0]   rr_q, rr_d;

    logic [NUM_CH-1:0] arb_req;
    logic [CH_W-1:0]   arb_ptr;
    logic [NUM_CH-1:0] arb_gnt;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_any;

    assign accept   = grant_valid_q & grant_ready;
    assign accepted = {NUM_CH{accept}} & grant_q;

    // A config write takes the whole edge for its channel, suppressing any expiry there.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_we && (int'(cfg_ch) == i);
            expire[i]  = 1'b0;
            div_d[i]   = div_q[i];
            cnt_d[i]   = cnt_q[i];
            if (cfg_hit[i]) begin
                div_d[i] = cfg_div;
                cnt_d[i] = cfg_div;
            end else if (!ch_en[i]) begin
                cnt_d[i] = div_q[i];
            end else if (tick_in) begin
                if (cnt_q[i] == '0) begin
                    cnt_d[i]  = div_q[i];
                    expire[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - DIV_W'(1);
                end
            end
        end
    end

    // A disabled channel keeps its pending bit only while it is the one on offer.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pending_d[i] = pending_q[i];
            if (expire[i]) begin
                pending_d[i] = 1'b1;
            end else if (accepted[i]) begin
                pending_d[i] = 1'b0;
            end else if (!ch_en[i] && !(grant_valid_q && grant_q[i])) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        arb_req = pending_q;
        arb_ptr = rr_q;
        if (state_q == ST_OFFER) begin
            arb_req = pending_q & ~grant_q;
            arb_ptr = grant_idx_q;
        end
    end

    tick_scheduler_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req     (arb_req),
        .ptr     (arb_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        rr_d          = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d       = arb_gnt;
                    grant_idx_d   = arb_idx;
                    grant_valid_d = 1'b1;
                    state_d       = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (accept) begin
                    rr_d = grant_idx_q;
                    if (arb_any) begin
                        grant_d     = arb_gnt;
                        grant_idx_d = arb_idx;
                    end else begin
                        grant_d       = '0;
                        grant_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            pending_q     <= '0;
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            rr_q          <= CH_W'(NUM_CH - 1);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            pending_q     <= pending_d;
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            rr_q          <= rr_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant       = grant_q;

`ifdef TICK_SCHEDULER_OVERRUN_EN
    logic [NUM_CH-1:0] overrun_q, overrun_d;

    // A fresh overrun beats a simultaneous clear.
    always_comb begin
        overrun_d = overrun_clr ? '0 : overrun_q;
        overrun_d = overrun_d | (expire & pending_q & ~accepted);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_overrun_clr;
    assign unused_overrun_clr = overrun_clr;
    assign overrun            = '0;
`endif

endmodule
